instr_predecode: RTL

INSTR_PREDECODE -- requirements
Module: instr_predecode

---
 rtl/instr_predecode.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/instr_predecode.sv
// Opcode predecode and interrupt sequencer: latches fetched opcodes, synchronises
// NMI/IRQ pins and substitutes a forced BRK (0x00) when RST/NMI/IRQ is pending.
//
// Ports:
//   phi2, rst                  clock, async active-high reset
//   RDY, SYNC                  fetch qualifier (fetch = SYNC & RDY)
//   dataIn                     opcode byte from the external bus
//   nmi_n, irq_n, iFlag        interrupt pins and I flag
//   intDone                    end of a BRK/interrupt sequence
//   opcodeOut, opcodeValid     opcode to control FSM, one-cycle load pulse
//   intSrc, intActive          active sequence source and service flag
//   nmi, irq, rst_o            pending flags to the control FSM
module instr_predecode (
  input  logic       phi2,
  input  logic       rst,
  input  logic       RDY,
  input  logic       SYNC,
  input  logic [7:0] dataIn,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       iFlag,
  input  logic       intDone,
  output logic [7:0] opcodeOut,
  output logic       opcodeValid,
  output logic [1:0] intSrc,
  output logic       intActive,
  output logic       nmi,
  output logic       irq,
  output logic       rst_o
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_IRQ  = 2'b01;
  localparam logic [1:0] SRC_NMI  = 2'b10;
  localparam logic [1:0] SRC_RST  = 2'b11;

  state_e     state_q, state_d;
  logic       nmi_s1_q, nmi_s2_q, nmi_s3_q;
  logic       irq_s1_q, irq_s2_q;
  logic       nmi_lat_q, nmi_lat_d;
  logic       rst_pend_q, rst_pend_d;
  logic [7:0] opcode_q, opcode_d;
  logic [1:0] src_q, src_d;
  logic       valid_q, valid_d;

  logic fetch;
  logic nmi_fall;
  logic irq_req;
  logic done;
  logic open_win;
  logic rst_after;
  logic take;
  logic acc_rst;
  logic acc_nmi;
  logic acc_irq;

  // Synchronisers and all state registers
  always_ff @(posedge phi2 or posedge rst) begin
    if (rst) begin
      state_q    <= SERVICE;
      nmi_s1_q   <= 1'b1;
      nmi_s2_q   <= 1'b1;
      nmi_s3_q   <= 1'b1;
      irq_s1_q   <= 1'b1;
      irq_s2_q   <= 1'b1;
      nmi_lat_q  <= 1'b0;
      rst_pend_q <= 1'b1;
      opcode_q   <= 8'h00;
      src_q      <= SRC_RST;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      nmi_s1_q   <= nmi_n;
      nmi_s2_q   <= nmi_s1_q;
      nmi_s3_q   <= nmi_s2_q;
      irq_s1_q   <= irq_n;
      irq_s2_q   <= irq_s1_q;
      nmi_lat_q  <= nmi_lat_d;
      rst_pend_q <= rst_pend_d;
      opcode_q   <= opcode_d;
      src_q      <= src_d;
      valid_q    <= valid_d;
    end
  end

  // Qualifiers. intDone is handled before the fetch in the same edge,
  // so a coinciding fetch sees the machine as already back in IDLE.
  always_comb begin
    fetch     = SYNC & RDY;
    nmi_fall  = nmi_s3_q & ~nmi_s2_q;
    irq_req   = ~irq_s2_q & ~iFlag;
    done      = (state_q == SERVICE) & intDone & RDY;
    open_win  = (state_q == IDLE) | done;
    rst_after = rst_pend_q & ~(done & (src_q == SRC_RST));
    take      = fetch & open_win;
    acc_rst   = take & rst_after;
    acc_nmi   = take & ~rst_after & nmi_lat_q;
    acc_irq   = take & ~rst_after & ~nmi_lat_q & irq_req;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (acc_rst | acc_nmi | acc_irq)
      state_d = SERVICE;
    else if (take | done)
      state_d = IDLE;
  end

  // Datapath and pending flags
  always_comb begin
    opcode_d   = opcode_q;
    src_d      = src_q;
    valid_d    = fetch;
    rst_pend_d = rst_after & ~acc_rst;
    // a new edge in the same cycle as acceptance keeps the latch set
    nmi_lat_d  = (nmi_lat_q & ~acc_nmi) | nmi_fall;
    if (take) begin
      unique case (1'b1)
        acc_rst: begin
          opcode_d = 8'h00;
          src_d    = SRC_RST;
        end
        acc_nmi: begin
          opcode_d = 8'h00;
          src_d    = SRC_NMI;
        end
        acc_irq: begin
          opcode_d = 8'h00;
          src_d    = SRC_IRQ;
        end
        default: begin
          opcode_d = dataIn;
          src_d    = SRC_NONE;
        end
      endcase
    end else if (done) begin
      src_d = SRC_NONE;
    end
  end

  // Outputs
  always_comb begin
    intActive   = (state_q == SERVICE);
    opcodeOut   = opcode_q;
    opcodeValid = valid_q;
    intSrc      = src_q;
    nmi         = nmi_lat_q;
    irq         = irq_req;
    rst_o       = rst_pend_q;
  end

endmodule
